fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, SHALL be the PC loaded on reset.
REQ-002 clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-004 rdy  in  1  SHALL be the global enable; when low, all state SHALL hold.
REQ-005 pc_if  out  32  SHALL be the current fetch PC driven to the predictor.
REQ-006 pre_jmp_status  in  1  SHALL be the predictor taken flag for pc_if.
REQ-007 pre_jmp_target  in  32  SHALL be the predicted target for pc_if.
REQ-008 mem_req  out  1  SHALL be the instruction-fetch request to memory control.
REQ-009 mem_addr  out  32  SHALL be the fetch address, equal to pc_if.
REQ-010 mem_ack  in  1  SHALL be a one-cycle pulse carrying the data for the held request.
REQ-011 mem_inst  in  32  SHALL be the fetched instruction, valid when mem_ack=1.
REQ-012 id_valid  out  1  SHALL flag that the output slot holds an instruction for decode.
REQ-013 id_inst, id_pc  out  32 each  SHALL be the slot instruction and its PC.
REQ-014 id_pre_jmp  out  1, id_pre_target  out  32  SHALL be the prediction captured with the slot.
REQ-015 id_ready  in  1  SHALL be decode acceptance; transfer occurs when id_valid and id_ready are both 1.
REQ-016 ex_jmp_wrong  in  1  SHALL flag a misprediction or redirect from execute.
REQ-017 ex_jmp_target  in  32  SHALL be the corrected PC, valid with ex_jmp_wrong.

Function
REQ-018 States SHALL be IDLE, REQ and DRAIN; mem_req SHALL be 1 exactly in REQ and DRAIN.
REQ-019 IDLE->REQ SHALL occur when the slot is empty or is transferred this cycle, with no redirect.
REQ-020 In REQ, pc and mem_addr SHALL stay stable until mem_ack.
REQ-021 On mem_ack in REQ: the slot SHALL load mem_inst, pc, pre_jmp_status, and pre_jmp_target (forced to 0 when not taken), and id_valid SHALL become 1.
REQ-022 On that same mem_ack, next pc SHALL be pre_jmp_target when pre_jmp_status=1, otherwise pc+4 modulo 2^32; the state SHALL go to IDLE.
REQ-023 Latency SHALL be: IDLE-to-request 1 cycle; mem_ack to id_valid 1 cycle.
REQ-024 A transfer SHALL clear id_valid on the next edge unless reloaded by mem_ack on the same edge.
REQ-025 The slot SHALL hold its contents unchanged while id_valid=1 and id_ready=0.
REQ-026 ex_jmp_wrong SHALL take priority over everything else: pc<=ex_jmp_target with bits [1:0] cleared, and id_valid<=0.
REQ-027 ex_jmp_wrong in IDLE SHALL leave the state in IDLE.
REQ-028 ex_jmp_wrong in REQ without mem_ack SHALL move to DRAIN, with mem_addr held at the old address until ack.
REQ-029 ex_jmp_wrong in REQ with mem_ack SHALL discard the data, load no slot, and go to IDLE.
REQ-030 In DRAIN, mem_ack SHALL discard the data and go to IDLE; a further ex_jmp_wrong SHALL update pc and stay in DRAIN.
REQ-031 During DRAIN, mem_addr SHALL keep the in-flight address, not the new pc.
REQ-032 rdy=0 SHALL freeze state, pc and slot; mem_req SHALL stay asserted if already asserted.

Reset
REQ-033 rst_n=0 SHALL asynchronously set pc=RESET_PC, state=IDLE, and id_valid=id_pre_jmp=0.
REQ-034 During reset, id_inst, id_pc and id_pre_target SHALL be 0 and mem_req SHALL be 0.
REQ-035 Deasserting rst_n mid-transaction SHALL restart cleanly; a stale mem_ack arriving in IDLE SHALL be ignored.
REQ-036 The first request after reset SHALL be at RESET_PC, on the second edge after release.

Verification
REQ-037 Sequential fetch: reset; mem_ack with 0x00000013 each request; no prediction -> id_pc sequence 0x0, 0x4, 0x8.
REQ-038 Predicted taken: pc_if=0x8 and pre_jmp_status=1, target 0x40 at ack -> slot id_pc=0x8 with id_pre_jmp=1 and id_pre_target=0x40; next mem_addr=0x40.
REQ-039 Backpressure: id_ready=0 for 5 cycles -> slot unchanged and no new mem_req; id_ready=1 -> transfer, then request on the next cycle.
REQ-040 Redirect mid-request: ex_jmp_wrong with target 0x100 while REQ at 0x20 -> DRAIN with mem_addr=0x20; ack discarded; next request at 0x100.
REQ-041 Redirect coincident with ack: ex_jmp_wrong target 0x203 -> no slot load, pc=0x200, id_valid=0.
REQ-042 rdy low for 3 cycles during REQ -> all outputs constant; wrap check: pc=0xFFFFFFFC sequential gives next pc 0x0.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: single-slot instruction fetch stage.
// Holds the fetch PC, issues one memory request at a time, and buffers the
// returned instruction together with its PC and prediction for decode.
// Ports:
//   clk, rst_n (async, active-low), rdy (global enable)
//   pc_if                 - current fetch PC to the branch predictor
//   pre_jmp_status/target - predictor result for pc_if
//   mem_req/mem_addr      - fetch request and address to memory control
//   mem_ack/mem_inst      - one-cycle response pulse and its data
//   id_valid/id_inst/id_pc/id_pre_jmp/id_pre_target - output slot to decode
//   id_ready              - decode acceptance
//   ex_jmp_wrong/ex_jmp_target - redirect from execute
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  output logic [31:0] pc_if,
  input  logic        pre_jmp_status,
  input  logic [31:0] pre_jmp_target,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_inst,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic        id_pre_jmp,
  output logic [31:0] id_pre_target,
  input  logic        id_ready,
  input  logic        ex_jmp_wrong,
  input  logic [31:0] ex_jmp_target
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] r_addr;
  logic        r_valid;
  logic        w_valid_nxt;
  logic        w_load;
  logic        w_xfer;
  logic [31:0] w_redir_pc;
  logic [31:0] r_inst;
  logic [31:0] r_id_pc;
  logic        r_pre_jmp;
  logic [31:0] r_pre_target;

  assign w_xfer     = r_valid & id_ready;
  assign w_redir_pc = {ex_jmp_target[31:2], 2'b00};

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_valid_nxt = r_valid;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        if (ex_jmp_wrong) begin
          w_pc_nxt    = w_redir_pc;
          w_valid_nxt = 1'b0;
        end else begin
          if (w_xfer) w_valid_nxt = 1'b0;
          if (!r_valid || id_ready) w_state_nxt = REQ;
        end
      end
      REQ: begin
        if (ex_jmp_wrong) begin
          w_pc_nxt    = w_redir_pc;
          w_valid_nxt = 1'b0;
          w_state_nxt = mem_ack ? IDLE : DRAIN;
        end else begin
          if (w_xfer) w_valid_nxt = 1'b0;
          if (mem_ack) begin
            w_load      = 1'b1;
            w_valid_nxt = 1'b1;
            w_pc_nxt    = pre_jmp_status ? pre_jmp_target : r_pc + 32'd4;
            w_state_nxt = IDLE;
          end
        end
      end
      DRAIN: begin
        if (ex_jmp_wrong) begin
          w_pc_nxt    = w_redir_pc;
          w_valid_nxt = 1'b0;
        end else if (w_xfer) begin
          w_valid_nxt = 1'b0;
        end
        // The outstanding ack closes the dead request even if another
        // redirect lands on the same edge; otherwise we would wait forever.
        if (mem_ack) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_pc         <= RESET_PC;
      r_addr       <= RESET_PC;
      r_valid      <= 1'b0;
      r_inst       <= '0;
      r_id_pc      <= '0;
      r_pre_jmp    <= 1'b0;
      r_pre_target <= '0;
    end else if (rdy) begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_valid <= w_valid_nxt;
      // Track the PC outside DRAIN so a redirect leaves the in-flight
      // address frozen here while pc moves on.
      if (r_state != DRAIN) r_addr <= r_pc;
      if (w_load) begin
        r_inst       <= mem_inst;
        r_id_pc      <= r_pc;
        r_pre_jmp    <= pre_jmp_status;
        r_pre_target <= pre_jmp_status ? pre_jmp_target : '0;
      end
    end
  end

  assign pc_if         = r_pc;
  assign mem_req       = (r_state != IDLE);
  assign mem_addr      = (r_state == DRAIN) ? r_addr : r_pc;
  assign id_valid      = r_valid;
  assign id_inst       = r_inst;
  assign id_pc         = r_id_pc;
  assign id_pre_jmp    = r_pre_jmp;
  assign id_pre_target = r_pre_target;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized self-checking bench for fetch_unit against a
// transaction-level reference model (outstanding-request flags + slot).
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        rdy;
  logic [31:0] pc_if;
  logic        pre_jmp_status;
  logic [31:0] pre_jmp_target;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_inst;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        id_pre_jmp;
  logic [31:0] id_pre_target;
  logic        id_ready;
  logic        ex_jmp_wrong;
  logic [31:0] ex_jmp_target;

  int unsigned n_vec;
  int unsigned n_err;

  // Reference model state
  logic [31:0] m_pc, m_addr, m_inst, m_ipc, m_pt;
  logic        m_busy, m_drop, m_valid, m_pj;

  fetch_unit #(.RESET_PC(32'h00000000)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .pc_if(pc_if),
    .pre_jmp_status(pre_jmp_status), .pre_jmp_target(pre_jmp_target),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_inst(mem_inst), .id_valid(id_valid), .id_inst(id_inst),
    .id_pc(id_pc), .id_pre_jmp(id_pre_jmp), .id_pre_target(id_pre_target),
    .id_ready(id_ready), .ex_jmp_wrong(ex_jmp_wrong),
    .ex_jmp_target(ex_jmp_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_addr = 32'h0; m_busy = 1'b0; m_drop = 1'b0;
    m_valid = 1'b0; m_inst = '0; m_ipc = '0; m_pj = 1'b0; m_pt = '0;
  endtask

  task automatic chk_all();
    chk("pc_if", pc_if, m_pc);
    chk("mem_req", {31'd0, mem_req}, {31'd0, m_busy});
    chk("mem_addr", mem_addr, m_busy ? m_addr : m_pc);
    chk("id_valid", {31'd0, id_valid}, {31'd0, m_valid});
    chk("id_inst", id_inst, m_inst);
    chk("id_pc", id_pc, m_ipc);
    chk("id_pre_jmp", {31'd0, id_pre_jmp}, {31'd0, m_pj});
    chk("id_pre_target", id_pre_target, m_pt);
  endtask

  // One clock: check outputs at negedge, apply inputs, advance the model
  // at the rising edge with the same inputs the DUT sees.
  task automatic step(input logic r, input logic a, input logic [31:0] inst,
                      input logic pj, input logic [31:0] pt, input logic idr,
                      input logic ex, input logic [31:0] et);
    logic xfer;
    @(negedge clk);
    chk_all();
    rdy = r; mem_ack = a; mem_inst = inst; pre_jmp_status = pj;
    pre_jmp_target = pt; id_ready = idr; ex_jmp_wrong = ex; ex_jmp_target = et;
    @(posedge clk);
    if (r) begin
      xfer = m_valid && idr;
      if (ex) begin
        m_pc = et & ~32'h3;
        m_valid = 1'b0;
        if (m_busy) begin
          if (a) m_busy = 1'b0;
          else   m_drop = 1'b1;
        end
      end else begin
        if (xfer) m_valid = 1'b0;
        if (!m_busy) begin
          if (!m_valid) begin
            m_busy = 1'b1; m_drop = 1'b0; m_addr = m_pc;
          end
        end else if (a) begin
          if (!m_drop) begin
            m_inst = inst; m_ipc = m_pc; m_pj = pj; m_pt = pj ? pt : 32'h0;
            m_valid = 1'b1;
            m_pc = pj ? pt : m_pc + 32'd4;
          end
          m_busy = 1'b0;
        end
      end
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_pc_if", pc_if, 32'h0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_id_inst", id_inst, 32'h0);
    chk("rst_id_pc", id_pc, 32'h0);
    chk("rst_id_pre_jmp", {31'd0, id_pre_jmp}, 32'd0);
    chk("rst_id_pre_target", id_pre_target, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs();
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst_n = 1'b0; rdy = 1'b0; mem_ack = 1'b0; mem_inst = '0;
    pre_jmp_status = 1'b0; pre_jmp_target = '0; id_ready = 1'b0;
    ex_jmp_wrong = 1'b0; ex_jmp_target = '0;
    model_reset();
    #3 chk_reset_outputs();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Sequential fetch of three words
    step(1, 0, 0, 0, 0, 1, 0, 0);
    for (int unsigned i = 0; i < 3; i++) begin
      step(1, 1, 32'h00000013, 0, 0, 1, 0, 0);
      #1 chk("seq_id_pc", id_pc, i * 4);
      step(1, 0, 0, 0, 0, 1, 0, 0);
    end
    // Predicted taken at pc 0xC -> target 0x40
    step(1, 1, 32'h00000013, 1, 32'h40, 1, 0, 0);
    #1 chk("pred_id_pre_target", id_pre_target, 32'h40);
    chk("pred_pc_if", pc_if, 32'h40);
    // Backpressure for 5 cycles: slot held, no new request
    for (int unsigned i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("bp_mem_req", {31'd0, mem_req}, 32'd0);
    step(1, 0, 0, 0, 0, 1, 0, 0);
    // Redirect in REQ -> DRAIN, ack discarded, then request at 0x100
    step(1, 0, 0, 0, 0, 1, 1, 32'h100);
    #1 chk("drain_mem_addr", mem_addr, 32'h40);
    step(1, 1, 32'hdeadbeef, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 1, 0, 0);
    #1 chk("redir_mem_addr", mem_addr, 32'h100);
    // Redirect coincident with ack
    step(1, 1, 32'h12345678, 0, 0, 1, 1, 32'h203);
    #1 chk("coinc_pc_if", pc_if, 32'h200);
    chk("coinc_id_valid", {31'd0, id_valid}, 32'd0);
    // rdy low for 3 cycles during REQ
    step(1, 0, 0, 0, 0, 1, 0, 0);
    for (int unsigned i = 0; i < 3; i++) step(0, 1, 32'h5, 1, 32'h80, 1, 1, 32'h300);
    // Wrap: pc 0xFFFFFFFC sequential -> 0
    step(1, 1, 32'h13, 0, 0, 1, 1, 32'hFFFFFFFC);
    step(1, 0, 0, 0, 0, 1, 0, 0);
    step(1, 1, 32'h13, 0, 0, 1, 0, 0);
    #1 chk("wrap_pc_if", pc_if, 32'h0);
    chk("wrap_id_pc", id_pc, 32'hFFFFFFFC);

    // Randomized traffic with occasional mid-run resets
    for (int unsigned blk = 0; blk < 3; blk++) begin
      for (int unsigned i = 0; i < 300; i++) begin
        step(($urandom_range(0, 99) < 85), ($urandom_range(0, 99) < 35), $urandom,
             $urandom_range(0, 1) == 1, $urandom, ($urandom_range(0, 99) < 60),
             ($urandom_range(0, 99) < 8), $urandom);
      end
      do_reset();
    end
    step(1, 0, 0, 0, 0, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
